// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: arbitrates and sequences the single-port data memory between the CPU port (p0) and the DMA/debug port (p1)
module dm_access_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [2:0]        p0_op,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [2:0]        p1_op,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [31:0]       p1_rdata,
  output logic              p0_stall,
  output logic              mem_en,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;
  state_t state, state_nx;
  logic owner, rr_last, we, grant, sel, g_we, g_bad, issue, done;
  logic [2:0] op, g_op;
  logic [31:0] addr, wdata, g_addr, ld_data, rsp_data;
  logic [1:0] lat_cnt;
  logic [15:0] half;
  logic [7:0] lane;
  // pick a winner (alternate under contention) and flag illegal or misaligned requests
  always_comb begin
    grant = p0_req | p1_req;
    sel = (p0_req & p1_req) ? ~rr_last : p1_req;
    g_we = sel ? p1_we : p0_we;
    g_op = sel ? p1_op : p0_op;
    g_addr = sel ? p1_addr : p0_addr;
    g_bad = (g_we ? ((g_op == 3'b010) | g_op[2]) : (g_op > 3'b100))
          | ((g_op == 3'b000) & (g_addr[1:0] != 2'b00))
          | (((g_op == 3'b001) | (g_op == 3'b010)) & g_addr[0]);
  end
  // next-state sequencing through issue, latency wait and response
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant ? (g_bad ? ERR : ISSUE) : IDLE;
      ISSUE:   state_nx = (MEM_LAT == 1) ? RESP : WAIT;
      WAIT:    state_nx = (lat_cnt == 2'(MEM_LAT - 2)) ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // state register, latency counter and latch of the granted transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      rr_last <= 1'b1;
      lat_cnt <= 2'd0;
      we <= 1'b0;
      op <= 3'b000;
      addr <= 32'h0;
      wdata <= 32'h0;
    end else begin
      state <= state_nx;
      lat_cnt <= (state == WAIT) ? lat_cnt + 2'd1 : 2'd0;
      if (state == IDLE && grant) begin
        owner <= sel;
        rr_last <= sel;
        we <= g_we;
        op <= g_op;
        addr <= g_addr;
        wdata <= sel ? p1_wdata : p0_wdata;
      end
    end
  end
  // memory strobes, lane steering and load extension decoded from registered state
  always_comb begin
    issue = state == ISSUE;
    done = (state == RESP) | (state == ERR);
    half = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    lane = mem_rdata[{addr[1:0], 3'b000} +: 8];
    ld_data = (op == 3'b001) ? {{16{half[15]}}, half}
            : (op == 3'b010) ? {16'h0, half}
            : (op == 3'b011) ? {{24{lane[7]}}, lane}
            : (op == 3'b100) ? {24'h0, lane} : mem_rdata;
    rsp_data = ((state == RESP) & ~we) ? ld_data : 32'h0;
    mem_en = issue;
    mem_addr = issue ? addr[MEM_AW+1:2] : '0;
    mem_be = (issue & we) ? ((op == 3'b000) ? 4'hF : (op == 3'b001) ? (addr[1] ? 4'hC : 4'h3) : 4'b0001 << addr[1:0]) : 4'h0;
    mem_wdata = (issue & we) ? ((op == 3'b000) ? wdata : (op == 3'b001) ? {2{wdata[15:0]}} : {4{wdata[7:0]}}) : 32'h0;
    p0_ack = done & ~owner;
    p1_ack = done & owner;
    p0_err = (state == ERR) & ~owner;
    p1_err = (state == ERR) & owner;
    p0_rdata = owner ? 32'h0 : rsp_data;
    p1_rdata = owner ? rsp_data : 32'h0;
    p0_stall = p0_req & ~p0_ack;
  end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: transaction-level model check of dm_access_ctrl plus directed literal checks
module tb_dm_access_ctrl;
  localparam int AW = 12;
  localparam int LA = 1;
  logic clk = 0;
  always #5 clk = ~clk;
  logic a_reset = 1, b_reset = 1;
  logic a_p0_req = 0, a_p0_we = 0, a_p1_req = 0, a_p1_we = 0;
  logic [2:0] a_p0_op = 0, a_p1_op = 0;
  logic [31:0] a_p0_addr = 0, a_p0_wdata = 0, a_p1_addr = 0, a_p1_wdata = 0;
  logic a_p0_ack, a_p0_err, a_p1_ack, a_p1_err, a_p0_stall, a_mem_en;
  logic [31:0] a_p0_rdata, a_p1_rdata, a_mem_wdata, a_mem_rdata;
  logic [3:0] a_mem_be;
  logic [AW-1:0] a_mem_addr;
  logic b_p0_req = 0, b_p0_we = 0, b_p1_req = 0, b_p1_we = 0;
  logic [2:0] b_p0_op = 0, b_p1_op = 0;
  logic [31:0] b_p0_addr = 0, b_p0_wdata = 0, b_p1_addr = 0, b_p1_wdata = 0;
  logic b_p0_ack, b_p0_err, b_p1_ack, b_p1_err, b_p0_stall, b_mem_en;
  logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_wdata, b_mem_rdata;
  logic [3:0] b_mem_be;
  logic [AW-1:0] b_mem_addr;
  int checks = 0, errors = 0, cyc = 0;

  dm_access_ctrl #(.MEM_LAT(1), .MEM_AW(AW)) u_a (
    .clk(clk), .reset(a_reset),
    .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_op(a_p0_op), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
    .p0_ack(a_p0_ack), .p0_err(a_p0_err), .p0_rdata(a_p0_rdata),
    .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_op(a_p1_op), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
    .p1_ack(a_p1_ack), .p1_err(a_p1_err), .p1_rdata(a_p1_rdata),
    .p0_stall(a_p0_stall), .mem_en(a_mem_en), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata));

  dm_access_ctrl #(.MEM_LAT(3), .MEM_AW(AW)) u_b (
    .clk(clk), .reset(b_reset),
    .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_op(b_p0_op), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
    .p0_ack(b_p0_ack), .p0_err(b_p0_err), .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_op(b_p1_op), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
    .p1_ack(b_p1_ack), .p1_err(b_p1_err), .p1_rdata(b_p1_rdata),
    .p0_stall(b_p0_stall), .mem_en(b_mem_en), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

  // data memories: one-cycle read for u_a, three-stage read pipe for u_b
  logic [31:0] mem_a [0:4095];
  logic [31:0] mem_bw [0:4095];
  logic [31:0] pb [3];
  always @(posedge clk) begin
    if (a_mem_en) begin
      for (int j = 0; j < 4; j++) if (a_mem_be[j]) mem_a[a_mem_addr][8*j +: 8] <= a_mem_wdata[8*j +: 8];
      a_mem_rdata <= mem_a[a_mem_addr];
    end
  end
  always @(posedge clk) begin
    if (b_mem_en) for (int j = 0; j < 4; j++) if (b_mem_be[j]) mem_bw[b_mem_addr][8*j +: 8] <= b_mem_wdata[8*j +: 8];
    pb[0] <= mem_bw[b_mem_addr];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign b_mem_rdata = pb[2];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, a, e);
    end
  endtask

  // model of u_a: a transaction granted in an idle cycle c strobes memory in c+1 and acks in c+1+LA (c+1 if rejected)
  logic [7:0] ref_mem [logic [31:0]];
  bit m_busy = 0, m_rr = 1, m_port, m_we, m_bad, m_sg;
  int m_en, m_ack, m_sz;
  logic [2:0] m_op;
  logic [31:0] m_addr, m_wdata, m_ld = 0;
  logic e_en, e_ack0, e_ack1, e_err0, e_err1;
  logic [3:0] e_be;
  logic [31:0] e_wd, e_rd0, e_rd1;
  logic [AW-1:0] e_ma;
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      e_en = 0; e_be = 0; e_wd = 0; e_ma = 0; e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0; e_rd0 = 0; e_rd1 = 0;
      if (m_busy && cyc == m_en && !m_bad) begin
        e_en = 1;
        e_ma = m_addr[AW+1:2];
        if (m_we) begin
          for (int i = 0; i < m_sz; i++) begin
            e_be[int'(m_addr[1:0]) + i] = 1'b1;
            ref_mem[m_addr + 32'(i)] = m_wdata[8*i +: 8];
          end
          for (int j = 0; j < 4; j++) e_wd[8*j +: 8] = m_wdata[8*(j % m_sz) +: 8];
        end else begin
          m_ld = 0;
          for (int i = 0; i < m_sz; i++) m_ld[8*i +: 8] = ref_mem[m_addr + 32'(i)];
          if (m_sg && m_ld[8*m_sz-1]) for (int i = 8*m_sz; i < 32; i++) m_ld[i] = 1'b1;
        end
      end
      if (m_busy && cyc == m_ack) begin
        if (m_port) begin e_ack1 = 1; e_err1 = m_bad; e_rd1 = (!m_we && !m_bad) ? m_ld : 0; end
        else begin e_ack0 = 1; e_err0 = m_bad; e_rd0 = (!m_we && !m_bad) ? m_ld : 0; end
      end
      chk("mem_en", a_mem_en, e_en);
      chk("mem_be", a_mem_be, e_be);
      chk("mem_addr", a_mem_addr, e_ma);
      chk("mem_wdata", a_mem_wdata, e_wd);
      chk("p0_ack", a_p0_ack, e_ack0);
      chk("p1_ack", a_p1_ack, e_ack1);
      chk("p0_err", a_p0_err, e_err0);
      chk("p1_err", a_p1_err, e_err1);
      chk("p0_rdata", a_p0_rdata, e_rd0);
      chk("p1_rdata", a_p1_rdata, e_rd1);
      chk("p0_stall", a_p0_stall, a_p0_req & ~e_ack0);
      if (m_busy && cyc == m_ack) m_busy = 0;
      else if (!m_busy && !a_reset && (a_p0_req || a_p1_req)) begin
        m_port = (a_p0_req && a_p1_req) ? !m_rr : a_p1_req;
        m_rr = m_port;
        m_we = m_port ? a_p1_we : a_p0_we;
        m_op = m_port ? a_p1_op : a_p0_op;
        m_addr = m_port ? a_p1_addr : a_p0_addr;
        m_wdata = m_port ? a_p1_wdata : a_p0_wdata;
        m_sz = (m_op == 0) ? 4 : (m_op == 1 || m_op == 2) ? 2 : 1;
        m_sg = !m_we && (m_op == 1 || m_op == 3);
        m_bad = m_we ? !(m_op inside {3'd0, 3'd1, 3'd3}) : (m_op > 3'd4);
        if (!m_bad && (int'(m_addr[1:0]) % m_sz) != 0) m_bad = 1;
        m_en = cyc + 1;
        m_ack = cyc + 1 + (m_bad ? 0 : LA);
        m_busy = 1;
      end
      if (a_reset) begin m_busy = 0; m_rr = 1; end
    end
  end

  task automatic acc(input bit port, input bit we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd_in,
                     output logic [31:0] rd, output bit er, output int lat, output logic [3:0] be, output logic [31:0] wd, output bit en);
    @(posedge clk); #1;
    if (port) begin a_p1_req = 1; a_p1_we = we; a_p1_op = op; a_p1_addr = addr; a_p1_wdata = wd_in; end
    else begin a_p0_req = 1; a_p0_we = we; a_p0_op = op; a_p0_addr = addr; a_p0_wdata = wd_in; end
    rd = 0; er = 0; lat = -1; be = 0; wd = 0; en = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (a_mem_en) begin en = 1; be = a_mem_be; wd = a_mem_wdata; end
      if (port ? a_p1_ack : a_p0_ack) begin
        lat = n - 1;
        rd = port ? a_p1_rdata : a_p0_rdata;
        er = port ? a_p1_err : a_p0_err;
        break;
      end
    end
    @(posedge clk); #1;
    a_p0_req = 0; a_p1_req = 0;
  endtask

  logic [31:0] rd, wd;
  logic [3:0] be;
  bit er, en, who;
  int lat, c0, c1;
  int order[$];
  initial begin
    repeat (3) @(posedge clk);
    #1; a_reset = 0; b_reset = 0;
    @(negedge clk);
    chk("rst_ctl", {a_p0_ack, a_p0_err, a_p1_ack, a_p1_err, a_p0_stall, a_mem_en, a_mem_be}, 0);
    chk("rst_data", a_p0_rdata | a_p1_rdata | a_mem_wdata | 32'(a_mem_addr), 0);
    // contention right after reset: p0 first, then strict alternation
    @(posedge clk); #1;
    a_p0_req = 1; a_p0_we = 1; a_p0_op = 0; a_p0_addr = 32'h400; a_p0_wdata = 32'h11111111;
    a_p1_req = 1; a_p1_we = 1; a_p1_op = 0; a_p1_addr = 32'h404; a_p1_wdata = 32'h22222222;
    c0 = 0; c1 = 0;
    for (int n = 0; n < 40 && order.size() < 4; n++) begin
      @(negedge clk);
      if (a_p0_ack) begin order.push_back(0); c0++; end
      if (a_p1_ack) begin order.push_back(1); c1++; end
      @(posedge clk); #1;
      if (c0 == 2) a_p0_req = 0;
      if (c1 == 2) a_p1_req = 0;
    end
    a_p0_req = 0; a_p1_req = 0;
    chk("t4_count", order.size(), 4);
    foreach (order[i]) chk("t4_order", order[i], i % 2);
    // word store and load
    acc(0, 1, 3'd0, 32'h100, 32'hDEADBEEF, rd, er, lat, be, wd, en);
    chk("t1_sw_be", be, 4'hF); chk("t1_sw_lat", lat, 2); chk("t1_sw_wd", wd, 32'hDEADBEEF);
    acc(0, 0, 3'd0, 32'h100, 0, rd, er, lat, be, wd, en);
    chk("t1_lw_data", rd, 32'hDEADBEEF); chk("t1_lw_lat", lat, 2); chk("t1_lw_be", be, 4'h0);
    // extension of sub-word loads from 0x80FF7F01
    acc(1, 1, 3'd0, 32'h200, 32'h80FF7F01, rd, er, lat, be, wd, en);
    acc(1, 0, 3'd3, 32'h203, 0, rd, er, lat, be, wd, en); chk("t2_lb_203", rd, 32'hFFFFFF80);
    acc(1, 0, 3'd4, 32'h201, 0, rd, er, lat, be, wd, en); chk("t2_lbu_201", rd, 32'h0000007F);
    acc(0, 0, 3'd4, 32'h202, 0, rd, er, lat, be, wd, en); chk("t2_lbu_202", rd, 32'h000000FF);
    acc(1, 0, 3'd1, 32'h202, 0, rd, er, lat, be, wd, en); chk("t2_lh_202", rd, 32'hFFFF80FF);
    acc(1, 0, 3'd2, 32'h200, 0, rd, er, lat, be, wd, en); chk("t2_lhu_200", rd, 32'h00007F01);
    acc(0, 0, 3'd3, 32'h201, 0, rd, er, lat, be, wd, en); chk("t2_lb_201", rd, 32'h0000007F);
    // sub-word stores: enables and lane replication
    acc(0, 1, 3'd3, 32'h302, 32'h000000AB, rd, er, lat, be, wd, en);
    chk("t3_sb_be", be, 4'b0100); chk("t3_sb_wd", wd, 32'hABABABAB);
    acc(0, 1, 3'd1, 32'h302, 32'h00001234, rd, er, lat, be, wd, en);
    chk("t3_sh_be", be, 4'b1100); chk("t3_sh_wd", wd, 32'h12341234);
    acc(1, 0, 3'd3, 32'h303, 0, rd, er, lat, be, wd, en); chk("t3_lb_303", rd, 32'h00000012);
    // rejected accesses: immediate error ack, no memory strobe
    acc(0, 0, 3'd0, 32'h102, 0, rd, er, lat, be, wd, en);
    chk("t5_lw_err", er, 1); chk("t5_lw_lat", lat, 1); chk("t5_lw_en", en, 0);
    acc(0, 1, 3'd1, 32'h101, 32'h5555, rd, er, lat, be, wd, en);
    chk("t5_sh_err", er, 1); chk("t5_sh_lat", lat, 1); chk("t5_sh_en", en, 0);
    acc(1, 1, 3'd4, 32'h100, 32'h5555, rd, er, lat, be, wd, en);
    chk("t5_op4_err", er, 1); chk("t5_op4_en", en, 0);
    acc(1, 0, 3'd5, 32'h100, 0, rd, er, lat, be, wd, en);
    chk("t5_ld5_err", er, 1); chk("t5_ld5_rd", rd, 0);
    acc(0, 0, 3'd0, 32'h100, 0, rd, er, lat, be, wd, en);
    chk("t5_mem_intact", rd, 32'hDEADBEEF); chk("t5_ok_err", er, 0);
    // three-cycle memory: store, then reset during the wait of a load
    @(posedge clk); #1;
    b_p0_req = 1; b_p0_we = 1; b_p0_op = 0; b_p0_addr = 32'h10; b_p0_wdata = 32'h12345678;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (b_p0_ack) begin lat = n - 1; break; end
    end
    chk("t6_sw_lat", lat, 4);
    @(posedge clk); #1; b_p0_we = 0;
    @(negedge clk); chk("t6_idle_en", b_mem_en, 0);
    @(negedge clk); chk("t6_issue_en", b_mem_en, 1); chk("t6_issue_addr", b_mem_addr, 4);
    @(posedge clk); #1; b_reset = 1;
    @(negedge clk); chk("t6_wait_ack", b_p0_ack | b_p1_ack, 0);
    @(posedge clk); #1;
    b_reset = 0; b_p1_req = 1; b_p1_we = 0; b_p1_op = 0; b_p1_addr = 32'h10;
    @(negedge clk);
    chk("t6_rst_ctl", {b_p0_ack, b_p0_err, b_p1_ack, b_p1_err, b_mem_en, b_mem_be}, 0);
    chk("t6_rst_data", b_p0_rdata | b_p1_rdata | b_mem_wdata | 32'(b_mem_addr), 0);
    chk("t6_rst_stall", b_p0_stall, 1);
    lat = -1; who = 1; rd = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (b_p0_ack | b_p1_ack) begin lat = n; who = b_p1_ack; rd = b_p0_rdata; break; end
    end
    chk("t6_lat", lat, 4); chk("t6_winner", who, 0); chk("t6_rdata", rd, 32'h12345678);
    @(posedge clk); #1; b_p0_req = 0; b_p1_req = 0;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
